fir_mac_sequencer: RTL and testbench

//  Control FSM for the time-multiplexed digital filter: accepts 8-bit samples over a

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_ptr_ring.sv | 44 ++++
 rtl/fir_mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Constants shared by the FIR sequencer and its datapath: default sizes, FSM state
// encodings and the wrap-by-compare modular subtract used for delay-line addressing.
package fir_pkg;

    localparam int TAPS_DEF = 4;
    localparam int DW_DEF   = 8;

    localparam logic [2:0] S_FLUSH = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // (ptr - k) mod taps without relying on power-of-two truncation.
    function automatic int mod_dec(input int ptr, input int k, input int taps);
        int r;
        if (ptr >= k) begin
            r = ptr - k;
        end else begin
            r = ptr + taps - k;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_ptr_ring.sv
// Modular up-counter 0..TAPS-1 with synchronous clear; wraps by explicit compare so
// TAPS need not be a power of two.
module fir_ptr_ring #(
    parameter int  TAPS = 4,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer: clear wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = {AW{1'b0}};
        end else if (inc_i) begin
            if (ptr_q == AW'(TAPS - 1)) begin
                ptr_d = {AW{1'b0}};
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= {AW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the time-multiplexed FIR: accepts samples, writes the circular delay
// line, walks the shared MAC across all taps and strobes the final result.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int  TAPS = TAPS_DEF,
    parameter int  DW   = DW_DEF,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          x_valid,
    input  logic [DW-1:0] x,
    output logic          x_ready,
    input  logic          flush,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] coef_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          y_load,
    output logic          busy
);

    // state_q / cnt_s name the slot the output registers load at the next edge.
    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [2:0]    eff_s;
    logic [AW-1:0] cnt_s;
    logic [AW-1:0] wptr_s;
    logic [AW-1:0] raddr_d;
    logic          cnt_wrap_s;
    logic          cnt_inc_s;
    logic          wptr_clr_s;
    logic          wptr_inc_s;
    logic          accept_s;

    logic          x_ready_q;
    logic          mem_we_q;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] coef_q;
    logic          issue_q;
    logic          acc_en_q;
    logic          y_load_q;
    logic          busy_q;

    fir_ptr_ring #(.TAPS(TAPS)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (cnt_inc_s),
        .ptr_o (cnt_s)
    );

    fir_ptr_ring #(.TAPS(TAPS)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (wptr_clr_s),
        .inc_i (wptr_inc_s),
        .ptr_o (wptr_s)
    );

    // The sample is only known in the accept cycle, so the write and clear ride it directly.
    always_comb begin
        accept_s = rst_n & x_ready_q & x_valid & ~flush;
    end

    // Slot to issue next; IDLE leaves only while x_ready is visible.
    always_comb begin
        eff_s = state_q;
        if (state_q == S_IDLE) begin
            if (x_ready_q && flush) begin
                eff_s = S_FLUSH;
            end else if (accept_s) begin
                eff_s = S_MAC;
            end else begin
                eff_s = S_IDLE;
            end
        end else begin
            eff_s = state_q;
        end
    end

    // Successor slot and counter controls.
    always_comb begin
        cnt_wrap_s = (cnt_s == AW'(TAPS - 1));
        cnt_inc_s  = (eff_s == S_FLUSH) || (eff_s == S_MAC);
        wptr_clr_s = (eff_s == S_FLUSH);
        wptr_inc_s = (eff_s == S_OUT);
        raddr_d    = AW'(mod_dec(int'(wptr_s), int'(cnt_s), TAPS));
        case (eff_s)
            S_FLUSH: state_d = cnt_wrap_s ? S_IDLE : S_FLUSH;
            S_IDLE:  state_d = S_IDLE;
            S_MAC:   state_d = cnt_wrap_s ? S_DRAIN : S_MAC;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_FLUSH;
        endcase
    end

    // State and registered outputs; acc_en trails the address issue by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FLUSH;
            x_ready_q <= 1'b0;
            mem_we_q  <= 1'b0;
            waddr_q   <= {AW{1'b0}};
            raddr_q   <= {AW{1'b0}};
            coef_q    <= {AW{1'b0}};
            issue_q   <= 1'b0;
            acc_en_q  <= 1'b0;
            y_load_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_ready_q <= (eff_s == S_IDLE);
            mem_we_q  <= (eff_s == S_FLUSH);
            waddr_q   <= (eff_s == S_FLUSH) ? cnt_s : {AW{1'b0}};
            raddr_q   <= (eff_s == S_MAC) ? raddr_d : {AW{1'b0}};
            coef_q    <= (eff_s == S_MAC) ? cnt_s : {AW{1'b0}};
            issue_q   <= (eff_s == S_MAC);
            acc_en_q  <= issue_q;
            y_load_q  <= (eff_s == S_OUT);
            busy_q    <= (eff_s != S_IDLE);
        end
    end

    assign x_ready   = x_ready_q;
    assign mem_we    = mem_we_q | accept_s;
    assign mem_waddr = accept_s ? wptr_s : waddr_q;
    assign mem_wdata = accept_s ? x : {DW{1'b0}};
    assign mem_raddr = raddr_q;
    assign coef_addr = coef_q;
    assign acc_clr   = accept_s;
    assign acc_en    = acc_en_q;
    assign y_load    = y_load_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: drives the sequencer with a small delay-line/MAC datapath model and
// compares its strobes and the filter result against an arithmetic FIR reference.
module tb_fir_mac_sequencer;

    localparam int TAPS = 4;
    localparam int DW   = 8;
    localparam int AW   = 2;

    logic          clk;
    logic          rst_n;
    logic          x_valid;
    logic [DW-1:0] x;
    logic          x_ready;
    logic          flush;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] coef_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          y_load;
    logic          busy;

    int n_checks;
    int n_fail;

    logic [DW-1:0] ram [TAPS];
    logic [DW-1:0] coef_rom [TAPS];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] cdata_q;
    logic [31:0]   acc;

    int hist [TAPS];
    int exp_wptr;

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x         (x),
        .x_ready   (x_ready),
        .flush     (flush),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .coef_addr (coef_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .y_load    (y_load),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter datapath stand-in: sync-read delay line, coefficient ROM, accumulator.
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        rdata_q <= ram[mem_raddr];
        cdata_q <= coef_rom[coef_addr];
        if (acc_clr) acc <= 32'd0;
        else if (acc_en) acc <= acc + 32'(rdata_q) * 32'(cdata_q);
    end

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        exp_wptr = 0;
    endtask

    // y[n] = sum_k c[k] * x[n-k]; also hands back the write slot used by this sample.
    task automatic model_accept(input logic [7:0] xv, output int wp, output int expy);
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(xv);
        expy = 0;
        for (int k = 0; k < TAPS; k++) expy += int'(coef_rom[k]) * hist[k];
        wp = exp_wptr;
        exp_wptr = (exp_wptr + 1) % TAPS;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (x_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (x_ready === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({x_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, coef_addr, acc_clr, acc_en, y_load, busy} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {x_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, coef_addr, acc_clr, acc_en, y_load, busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_we, mem_waddr, mem_wdata, x_ready, busy} !== {1'b1, AW'(i), 8'h00, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_flush[%0d]: we=%b waddr=%0d wdata=%h ready=%b busy=%b required we=1 waddr=%0d wdata=00 ready=0 busy=1",
                         i, mem_we, mem_waddr, mem_wdata, x_ready, busy, i);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({x_ready, busy, mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle: ready/busy/we=%b required 100", {x_ready, busy, mem_we});
        end
    endtask

    task automatic test_single_sample(input logic [7:0] xv);
        bit ok;
        int wp, expy;
        logic [5:0] exp_s;
        wait_ready(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_ready: x_ready=%b required 1", x_ready);
        end else begin
            x = xv;
            x_valid = 1'b1;
            #1;
            model_accept(xv, wp, expy);
            n_checks++;
            if ({mem_we, mem_waddr, mem_wdata, acc_clr} !== {1'b1, AW'(wp), xv, 1'b1}) begin
                n_fail++;
                $display("FAIL single_write: we=%b waddr=%0d wdata=%h clr=%b required 1 %0d %h 1",
                         mem_we, mem_waddr, mem_wdata, acc_clr, wp, xv);
            end
            @(posedge clk);
            #1;
            x_valid = 1'b0;
            for (int t = 1; t <= TAPS + 3; t++) begin
                @(negedge clk);
                exp_s = {(t >= 2 && t <= TAPS + 1), (t == TAPS + 2), (t == TAPS + 3), (t <= TAPS + 2), 1'b0, 1'b0};
                n_checks++;
                if ({acc_en, y_load, x_ready, busy, mem_we, acc_clr} !== exp_s) begin
                    n_fail++;
                    $display("FAIL single_strobes t=%0d: en/load/ready/busy/we/clr=%b required %b",
                             t, {acc_en, y_load, x_ready, busy, mem_we, acc_clr}, exp_s);
                end
                if (t <= TAPS) begin
                    n_checks++;
                    if ({mem_raddr, coef_addr} !== {AW'((wp - (t - 1) + TAPS) % TAPS), AW'(t - 1)}) begin
                        n_fail++;
                        $display("FAIL single_addr t=%0d: raddr=%0d coef=%0d required %0d %0d",
                                 t, mem_raddr, coef_addr, (wp - (t - 1) + TAPS) % TAPS, t - 1);
                    end
                end
                if (t == TAPS + 2) begin
                    n_checks++;
                    if (acc !== 32'(expy)) begin
                        n_fail++;
                        $display("FAIL single_y: acc=%0d required %0d", acc, expy);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        wait_ready(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_ready: x_ready=%b required 1", x_ready);
        end
        flush = 1'b1;
        x_valid = 1'b1;
        x = 8'($urandom);
        #1;
        n_checks++;
        if ({mem_we, acc_clr} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_no_accept: we/clr=%b required 00", {mem_we, acc_clr});
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        x_valid = 1'b0;
        model_reset();
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_we, mem_waddr, mem_wdata, x_ready, busy} !== {1'b1, AW'(i), 8'h00, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL flush_write[%0d]: we=%b waddr=%0d wdata=%h ready=%b busy=%b required 1 %0d 00 0 1",
                         i, mem_we, mem_waddr, mem_wdata, x_ready, busy, i);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({x_ready, mem_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_idle: ready/we=%b required 10", {x_ready, mem_we});
        end
    endtask

    task automatic test_back_to_back();
        int last, nacc, nload, wp, expy, cyc, o;
        int expq[$];
        logic [7:0] xv;
        bit acc_now;
        nacc = 0; nload = 0; last = 0; wp = 0; cyc = 0;
        xv = 8'd1;
        x = xv;
        x_valid = 1'b1;
        #1;
        while ((nacc < 5 || nload < 5) && cyc < 60) begin
            acc_now = (x_ready === 1'b1) && x_valid;
            o = cyc - last;
            if (acc_now) begin
                if (nacc > 0) begin
                    n_checks++;
                    if (o !== TAPS + 3) begin
                        n_fail++;
                        $display("FAIL b2b_gap: accepts %0d cycles apart required %0d", o, TAPS + 3);
                    end
                end
                model_accept(xv, wp, expy);
                expq.push_back(expy);
                n_checks++;
                if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, AW'(wp), xv}) begin
                    n_fail++;
                    $display("FAIL b2b_write: we=%b waddr=%0d wdata=%h required 1 %0d %h",
                             mem_we, mem_waddr, mem_wdata, wp, xv);
                end
                last = cyc;
                nacc++;
            end else if (nacc > 0 && o >= 1 && o <= TAPS) begin
                n_checks++;
                if ({mem_we, mem_raddr} !== {1'b0, AW'((wp - (o - 1) + TAPS) % TAPS)}) begin
                    n_fail++;
                    $display("FAIL b2b_read: we=%b raddr=%0d required 0 %0d", mem_we, mem_raddr, (wp - (o - 1) + TAPS) % TAPS);
                end
            end
            if (y_load === 1'b1) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_y: y_load=1 with no sample outstanding, required 0");
                end else begin
                    expy = expq.pop_front();
                    if (acc !== 32'(expy)) begin
                        n_fail++;
                        $display("FAIL b2b_y: acc=%0d required %0d", acc, expy);
                    end
                end
                nload++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (nacc < 5) begin
                    xv = xv + 8'd1;
                    x = xv;
                end else begin
                    x_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        x_valid = 1'b0;
        n_checks++;
        if (nacc != 5 || nload != 5) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d loads=%0d required 5 5", nacc, nload);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int wpa, wpb, expa, expb, n;
        logic [7:0] xa, xb;
        wait_ready(ok);
        xa = 8'($urandom);
        xb = 8'($urandom);
        x = xa;
        x_valid = 1'b1;
        #1;
        model_accept(xa, wpa, expa);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        for (int t = 1; t <= TAPS + 3; t++) begin
            @(negedge clk);
            if (t == 3) begin
                x = xb;
                x_valid = 1'b1;
                #1;
            end
            if (t >= 3 && t <= TAPS + 2) begin
                n_checks++;
                if ({mem_we, x_ready, acc_clr} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL busy_ignore t=%0d: we/ready/clr=%b required 000", t, {mem_we, x_ready, acc_clr});
                end
            end
            if (t == TAPS + 2) begin
                n_checks++;
                if (acc !== 32'(expa)) begin
                    n_fail++;
                    $display("FAIL busy_y_first: acc=%0d required %0d", acc, expa);
                end
            end
        end
        model_accept(xb, wpb, expb);
        n_checks++;
        if ({x_ready, mem_we, mem_waddr, mem_wdata} !== {1'b1, 1'b1, AW'(wpb), xb}) begin
            n_fail++;
            $display("FAIL busy_late_accept: ready=%b we=%b waddr=%0d wdata=%h required 1 1 %0d %h",
                     x_ready, mem_we, mem_waddr, mem_wdata, wpb, xb);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        n = 0;
        while (y_load !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (y_load !== 1'b1 || acc !== 32'(expb)) begin
            n_fail++;
            $display("FAIL busy_y_second: y_load=%b acc=%0d required 1 %0d", y_load, acc, expb);
        end
    endtask

    task automatic test_reset_mid_mac();
        bit ok;
        wait_ready(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmac_ready: x_ready=%b required 1", x_ready);
        end
        x = 8'($urandom);
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({acc_en, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmac_t2: acc_en/busy=%b required 11", {acc_en, busy});
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({x_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, coef_addr, acc_clr, acc_en, y_load, busy} !== 20'd0) begin
                n_fail++;
                $display("FAIL rstmac_zero[%0d]: got %b required all zero", i,
                         {x_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, coef_addr, acc_clr, acc_en, y_load, busy});
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_we, mem_waddr, mem_wdata, y_load} !== {1'b1, AW'(i), 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL rstmac_flush[%0d]: we=%b waddr=%0d wdata=%h y_load=%b required 1 %0d 00 0",
                         i, mem_we, mem_waddr, mem_wdata, y_load, i);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({x_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmac_idle: ready/busy=%b required 10", {x_ready, busy});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_single_sample(8'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x_valid = 1'b0;
        x = 8'h00;
        flush = 1'b0;
        n_checks = 0;
        n_fail = 0;
        for (int k = 0; k < TAPS; k++) coef_rom[k] = 8'($urandom);
        model_reset();
        test_reset();
        test_single_sample(8'h01);
        test_flush();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_mac();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
